digest_window_scanner: RTL and testbench

Parametrised successor to the fixed 256-bit/16-bit hash display selector. Captures a completed digest from the hash core into a holding register and presents one WIN_W-bit window of it to the 7-segment driver. Window selection is either manual (switch index) or automatic (timed scroll with a step input). Sits between the hash core's result/done outputs and segment_driver, on the system clock.

---
 rtl/digest_disp_pkg.sv | 15 +
 rtl/scroll_ticker.sv | 46 ++++
 rtl/digest_window_scanner.sv | 112 +++++++++++
 tb/tb_digest_window_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/digest_disp_pkg.sv
// Shared types and defaults for the digest window display path.
package digest_disp_pkg;

  typedef enum logic [1:0] {IDLE, MAN, AUTO} state_t;

  localparam int          DIGEST_W_DEF  = 256;
  localparam int          WIN_W_DEF     = 16;
  localparam logic [15:0] EMPTY_PAT_DEF = 16'hAAAA;

  // Window index width; a single-window digest still needs a 1-bit index.
  function automatic int sel_width(input int n_win);
    return (n_win > 1) ? $clog2(n_win) : 1;
  endfunction

endpackage

// File: rtl/scroll_ticker.sv
// Auto-scroll timebase: tick counter, step rising-edge detector and index wrap.
// advance is a single-cycle pulse; a tick and a step edge together give one pulse.
module scroll_ticker #(
  parameter int TICK_DIV = 125000000,
  parameter int N_WIN    = 16,
  parameter int SEL_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             step,
  input  logic [SEL_W-1:0] idx,
  output logic             advance,
  output logic [SEL_W-1:0] idx_next
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_WIN - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic             step_q;
  logic             step_rise;
  logic             tick;

  assign step_rise = step & ~step_q;
  assign tick      = (tick_cnt == CNT_LAST);
  assign advance   = en & (tick | step_rise);
  assign idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Counter sits at zero outside AUTO so that entry always starts a fresh period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      step_q   <= 1'b0;
    end else begin
      step_q <= step;
      if (!en || clr || advance)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digest_window_scanner.sv
// Captures a hash digest and presents one WIN_W-bit window of it, manual or auto-scrolled.
// Define DIGEST_MATCH_EN to add the EXPECTED parameter and a registered match flag.
module digest_window_scanner
  import digest_disp_pkg::*;
#(
  parameter int                DIGEST_W  = DIGEST_W_DEF,
  parameter int                WIN_W     = WIN_W_DEF,
  parameter int                TICK_DIV  = 125000000,
  parameter logic [WIN_W-1:0]  EMPTY_PAT = WIN_W'(EMPTY_PAT_DEF),
`ifdef DIGEST_MATCH_EN
  parameter logic [DIGEST_W-1:0] EXPECTED = '0,
`endif
  localparam int               N_WIN     = DIGEST_W / WIN_W,
  localparam int               SEL_W     = sel_width(N_WIN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                digest_valid,
  input  logic                hold,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic                step,
  output logic [WIN_W-1:0]    window,
  output logic [SEL_W-1:0]    win_idx,
  output logic                loaded,
  output logic                match
);

  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_WIN - 1);

  state_t                        state;
  logic [N_WIN-1:0][WIN_W-1:0]   digest_q;
  logic                          capture;
  logic                          auto_en;
  logic                          auto_clr;
  logic                          advance;
  logic [SEL_W-1:0]              idx_next;
  logic [SEL_W-1:0]              sel_clamped;

  assign capture     = digest_valid & ~hold;
  assign auto_en     = (state == AUTO);
  assign auto_clr    = capture & auto_en;
  assign sel_clamped = (sel_in > IDX_LAST) ? IDX_LAST : sel_in;

  scroll_ticker #(
    .TICK_DIV (TICK_DIV),
    .N_WIN    (N_WIN),
    .SEL_W    (SEL_W)
  ) u_ticker (
    .clk      (clk),
    .rst      (rst),
    .en       (auto_en),
    .clr      (auto_clr),
    .step     (step),
    .idx      (win_idx),
    .advance  (advance),
    .idx_next (idx_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      digest_q <= '0;
      loaded   <= 1'b0;
      win_idx  <= '0;
    end else begin
      if (capture) begin
        digest_q <= digest;
        loaded   <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (capture) begin
            state   <= mode ? AUTO : MAN;
            win_idx <= '0;
          end
        end
        MAN: begin
          // Index is kept across the switch to AUTO rather than reloaded from sel_in.
          if (mode)
            state <= AUTO;
          else
            win_idx <= sel_clamped;
        end
        AUTO: begin
          if (!mode)
            state <= MAN;
          if (capture)
            win_idx <= '0;
          else if (advance)
            win_idx <= idx_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign window = (state == IDLE) ? EMPTY_PAT : digest_q[win_idx];

`ifdef DIGEST_MATCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match <= 1'b0;
    else if (capture)
      match <= (digest == EXPECTED);
  end
`else
  assign match = 1'b0;
`endif

endmodule

// File: tb/tb_digest_window_scanner.sv
// Directed bench for digest_window_scanner with TICK_DIV=4, 256-bit digest, 16-bit windows.
module tb_digest_window_scanner;

  localparam logic [255:0] D1 = 256'hd0e8_b8f1_1234_5678_9abc_def0_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0_75a4_6271;
  localparam logic [255:0] D2 = 256'hffee_ddcc_bbaa_9988_7766_5544_3322_1100_0f0f_f0f0_1234_abcd_5a5a_a5a5_c0de_beef;
  localparam logic [15:0]  EMPTY = 16'hAAAA;
`ifdef DIGEST_MATCH_EN
  localparam logic MATCH_D1 = 1'b1;
`else
  localparam logic MATCH_D1 = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] digest;
  logic         digest_valid;
  logic         hold;
  logic         mode;
  logic [3:0]   sel_in;
  logic         step;
  logic [15:0]  window;
  logic [3:0]   win_idx;
  logic         loaded;
  logic         match;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  digest_window_scanner #(
    .DIGEST_W  (256),
    .WIN_W     (16),
    .TICK_DIV  (4),
    .EMPTY_PAT (16'hAAAA)
`ifdef DIGEST_MATCH_EN
    , .EXPECTED (D1)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digest       (digest),
    .digest_valid (digest_valid),
    .hold         (hold),
    .mode         (mode),
    .sel_in       (sel_in),
    .step         (step),
    .window       (window),
    .win_idx      (win_idx),
    .loaded       (loaded),
    .match        (match)
  );

  function automatic logic [15:0] ew(input logic [255:0] d, input int i);
    return d[i*16 +: 16];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] w, input logic [3:0] i, input logic l);
    check({tag, ".window"}, {240'd0, window}, {240'd0, w});
    check({tag, ".win_idx"}, {252'd0, win_idx}, {252'd0, i});
    check({tag, ".loaded"}, {255'd0, loaded}, {255'd0, l});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; digest = '0; digest_valid = 1'b0; hold = 1'b0;
    mode = 1'b0; sel_in = 4'd0; step = 1'b0;
    #1;
    chk("in_reset", EMPTY, 4'd0, 1'b0);
    check("in_reset.match", {255'd0, match}, 256'd0);
    #12 rst = 1'b1;
    cyc(1);

    // No capture yet: selection and step activity must not leave IDLE.
    sel_in = 4'd9;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk("idle_man", EMPTY, 4'd0, 1'b0);
    end
    mode = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step = ~step;
      cyc(1);
      chk("idle_auto", EMPTY, 4'd0, 1'b0);
    end

    mode = 1'b0; sel_in = 4'd0; step = 1'b0;
    digest = D1; digest_valid = 1'b1;
    cyc(1);
    digest_valid = 1'b0;
    chk("cap1", ew(D1, 0), 4'd0, 1'b1);
    check("cap1.match", {255'd0, match}, {255'd0, MATCH_D1});
    cyc(1);
    chk("man_sel0", ew(D1, 0), 4'd0, 1'b1);
    sel_in = 4'd15;
    cyc(1);
    chk("man_sel15", ew(D1, 15), 4'd15, 1'b1);
    sel_in = 4'd7;
    cyc(1);
    chk("man_sel7", ew(D1, 7), 4'd7, 1'b1);
    sel_in = 4'd5;
    cyc(1);
    chk("man_sel5", ew(D1, 5), 4'd5, 1'b1);

    mode = 1'b1;
    cyc(1);
    chk("auto_entry", ew(D1, 5), 4'd5, 1'b1);
    cyc(3);
    chk("auto_wait", ew(D1, 5), 4'd5, 1'b1);
    cyc(1);
    chk("auto_tick1", ew(D1, 6), 4'd6, 1'b1);
    cyc(4);
    chk("auto_tick2", ew(D1, 7), 4'd7, 1'b1);
    cyc(1);
    step = 1'b1;
    cyc(1);
    chk("step_edge", ew(D1, 8), 4'd8, 1'b1);
    cyc(3);
    chk("step_held", ew(D1, 8), 4'd8, 1'b1);
    cyc(1);
    chk("tick_after_step", ew(D1, 9), 4'd9, 1'b1);
    step = 1'b0;
    cyc(3);
    step = 1'b1;
    cyc(1);
    chk("tick_step_same", ew(D1, 10), 4'd10, 1'b1);
    cyc(1);
    chk("tick_step_once", ew(D1, 10), 4'd10, 1'b1);
    step = 1'b0;
    cyc(1);
    for (int k = 11; k <= 15; k++) begin
      step = 1'b1;
      cyc(1);
      chk("step_walk", ew(D1, k), 4'(k), 1'b1);
      step = 1'b0;
      cyc(1);
    end
    cyc(2);
    chk("pre_wrap", ew(D1, 15), 4'd15, 1'b1);
    cyc(1);
    chk("wrap", ew(D1, 0), 4'd0, 1'b1);

    cyc(4);
    chk("post_wrap", ew(D1, 1), 4'd1, 1'b1);
    cyc(3);
    step = 1'b1; digest = D2; digest_valid = 1'b1;
    cyc(1);
    digest_valid = 1'b0; step = 1'b0;
    chk("cap_tick_step", ew(D2, 0), 4'd0, 1'b1);
    check("cap_tick_step.match", {255'd0, match}, 256'd0);
    cyc(3);
    chk("cap_hold_idx", ew(D2, 0), 4'd0, 1'b1);
    cyc(1);
    chk("cap_next_tick", ew(D2, 1), 4'd1, 1'b1);

    mode = 1'b0; sel_in = 4'd1;
    cyc(2);
    chk("back_to_man", ew(D2, 1), 4'd1, 1'b1);
    hold = 1'b1; digest = D1; digest_valid = 1'b1;
    cyc(3);
    chk("hold_blocks", ew(D2, 1), 4'd1, 1'b1);
    sel_in = 4'd0;
    cyc(1);
    chk("hold_sel", ew(D2, 0), 4'd0, 1'b1);
    check("hold_sel.match", {255'd0, match}, 256'd0);
    hold = 1'b0; digest_valid = 1'b0;
    cyc(1);
    digest_valid = 1'b1;
    cyc(1);
    digest_valid = 1'b0;
    chk("unhold_cap", ew(D1, 0), 4'd0, 1'b1);
    check("unhold_cap.match", {255'd0, match}, {255'd0, MATCH_D1});

    mode = 1'b1;
    cyc(2);
    digest = D2; digest_valid = 1'b1;
    cyc(1);
    digest_valid = 1'b0;
    chk("cap_auto", ew(D2, 0), 4'd0, 1'b1);
    cyc(3);
    chk("cap_clears_tick", ew(D2, 0), 4'd0, 1'b1);
    cyc(1);
    chk("cap_tick_resume", ew(D2, 1), 4'd1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(1);
    end
    chk("pre_reset", ew(D2, 7), 4'd7, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", EMPTY, 4'd0, 1'b0);
    check("async_reset.match", {255'd0, match}, 256'd0);
    rst = 1'b1;
    cyc(2);
    chk("after_reset", EMPTY, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
